mem_access_unit: RTL
====================

# mem_access_unit

Initiator-side load/store sequencer that sits between the CPU datapath and the byte-lane data memory. It accepts one load or store per handshake and drives the memory's address, size, write-data and enable pins. Loads return lane-extracted, optionally sign-extended data. Accesses the memory cannot perform natively are converted into aligned word reads and read-modify-write sequences: misaligned halfwords, misaligned words, and accesses that span two words.

## Interface
- `MEM_ADDR`, default 16'h1000: value required on addr[31:16] for a legal access (both words of a spanning access).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 3 = word; 2 is illegal.
- `req_signed` in 1: sign-extend load data.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes response.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: illegal size or out-of-region address.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_size` out 2: memory size code, same encoding as req_size.
- `mem_we` out 1: memory write enable; memory commits on the clock edge.
- `mem_re` out 1: memory read enable.
- `mem_rdata` in 32: combinational memory read of mem_addr word.

## Operation
- Accept on `req_valid && req_ready`; latch `we`, `addr`, `size`, `signed`, `wdata`. Let `off = addr[1:0]`, `n = 1/2/4` bytes, `A0 = {addr[31:2],2'b00}`, `A1 = A0 + 4`.
- `span = off + n > 4`. `native = size==0 || (size==1 && off[0]==0) || (size==3 && off==0)`.
- Error if `size==2`, `A0[31:16] != MEM_ADDR`, or `span && A1[31:16] != MEM_ADDR`. On error: RESP with `resp_err=1`; no `mem_we` pulse is ever issued.
- FSM states:
  - IDLE: on accept, go to ERR-RESP, WNAT, or RD0.
  - WNAT: native store. Drives `A`, `req_size`, raw `wdata`, `mem_we=1` (the memory replicates lanes). Then RESP.
  - RD0: `mem_re=1`, `mem_addr=A0`; capture `mem_rdata` into `buf[31:0]`. Next state is RD1 if span. Otherwise RESP for a load, or WR0 for a store.
  - RD1: `mem_re=1`, `mem_addr=A1`; capture into `buf[63:32]`. Next state is RESP for a load, WR0 for a store.
  - WR0: `mem_we=1`, `mem_size=3`, `mem_addr=A0`, `mem_wdata=merged[31:0]`. Then WR1 if span, else RESP.
  - WR1: same as WR0 with `A1` and `merged[63:32]`. Then RESP.
  - RESP: `resp_valid=1`; return to IDLE on `resp_ready`.
- Loads, native or not, always use RD0 (plus RD1 if span) and never use `mem_size` ≠ 3.
- Load data: `raw = buf >> (8*off)`. Take the low `n` bytes, sign- or zero-extend per `req_signed`; word loads ignore `req_signed`.
- Store merge: lanes `off .. off+n-1` of the 64-bit `buf` are replaced by the low `n` bytes of `wdata`, with byte 0 at lane `off`. All other lanes keep the values read.
- When `mem_we` and `mem_re` are both 0, `mem_addr`, `mem_wdata` and `mem_size` hold 0.

## Timing
- Reset values: `req_ready=1` (IDLE); `resp_valid`, `resp_err`, `resp_rdata`, `mem_we`, `mem_re`, `mem_addr`, `mem_wdata`, `mem_size` all 0.
- Latency from accept edge to `resp_valid`, all with `resp_ready` held high:
  - Native store and error: 2 cycles.
  - Load, non-span: 2 cycles. Load, span: 3 cycles.
  - Non-native store, non-span: 3 cycles. Non-native store, span: 5 cycles.
- Memory outputs are registered state decodes, glitch-free and stable for the whole state.
- RESP holds all response fields stable until `resp_ready`. The next request can be accepted only the cycle after leaving RESP; there is no overlap.
- Reset asserted mid-sequence returns the FSM to IDLE immediately and drops `mem_we` asynchronously. If reset lands between WR0 and WR1, only word A0 has been updated; this is accepted, and no recovery is done.
- A0 wrap at `0xFFFFFFFC`: A1 wraps to 0 and fails the region check, so the access is an error.

## Structure
- Shared package `mem_access_pkg`:
  - Size codes `SZ_BYTE`, `SZ_HALF`, `SZ_UNALIGNED`, `SZ_WORD`.
  - FSM state enum.
  - Function `bytes_of(size)`.
- One sub-module, `lane_merge`: combinational extract (`shift + extend`) and merge (`mask + insert`) over the 64-bit buffer. The FSM, latches and handshake live in the top level.

## Test plan
- **Native word store then load:** store 0xDEADBEEF at 0x10000008, then load word at the same address → one `mem_we` cycle with size 3; `resp_rdata=0xDEADBEEF`, latencies 2 and 2.
- **Signed byte load:** memory word 0x10000004 = 0x80FF7F01; signed byte load at 0x10000006 → `0xFFFFFFFF`. Unsigned byte load at 0x10000007 → `0x00000080`.
- **Spanning word load:** word 0 = 0x44332211, word 1 = 0x88776655; load word at 0x10000002 → `0x66554433`, 3-cycle latency, `mem_re` asserted at A0 then A1.
- **Spanning half store:** store half 0xBEEF at 0x10000003 with words 0/1 = 0x44332211 / 0x88776655 → RD0, RD1, WR0, WR1 sequence; words become 0xEF332211 / 0x887766BE; latency 5.
- **Errors:** `req_size=2`, or a word store at 0x2000000C, or a half store at 0x1000FFFF (A1 leaves the region) → `resp_err=1`, `resp_rdata=0`, zero `mem_we` cycles, latency 2.
- **Reset mid-sequence:** assert reset during WR1 of a spanning store → outputs go to reset values within the same cycle; after release `req_ready=1`, and a following load returns the partially-written A0 and unchanged A1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the load/store sequencer and its lane helper.
//   SZ_*       : memory/request size codes (byte, half, illegal, word)
//   state_e    : sequencer FSM states
//   bytes_of() : number of bytes moved by a size code (0 for the illegal code)
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE      = 2'd0;
  localparam logic [1:0] SZ_HALF      = 2'd1;
  localparam logic [1:0] SZ_UNALIGNED = 2'd2;
  localparam logic [1:0] SZ_WORD      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_WNAT,
    ST_RD0,
    ST_RD1,
    ST_WR0,
    ST_WR1,
    ST_RESP
  } state_e;

  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: bytes_of = 3'd1;
      SZ_HALF: bytes_of = 3'd2;
      SZ_WORD: bytes_of = 3'd4;
      default: bytes_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// lane_merge
// Purely combinational byte-lane helper working on the 64-bit read buffer
// (word A0 in bits [31:0], word A1 in bits [63:32]).
//   buf_data : words read from memory
//   off      : byte offset of the access inside word A0
//   size     : access size code
//   sign_ext : sign-extend byte/half load data
//   wdata    : right-justified store data
//   rdata    : extracted and extended load result
//   merged   : buf_data with the store bytes inserted at lanes off..off+n-1
module lane_merge
  import mem_access_pkg::*;
(
  input  logic [63:0] buf_data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;
  logic [63:0] bit_mask;
  logic [63:0] ins;

  assign shamt = {off, 3'b000};

  always_comb begin
    shifted = buf_data >> shamt;
    case (size)
      SZ_BYTE: rdata = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted[31:0];
    endcase
  end

  // Lane mask is built per byte, then widened to a bit mask so the insert
  // only touches the lanes the access covers, possibly across both words.
  always_comb begin
    case (size)
      SZ_BYTE: base_mask = 8'h01;
      SZ_HALF: base_mask = 8'h03;
      SZ_WORD: base_mask = 8'h0F;
      default: base_mask = 8'h00;
    endcase
    lane_mask = base_mask << off;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    ins    = {32'b0, wdata} << shamt;
    merged = (buf_data & ~bit_mask) | (ins & bit_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer between the CPU datapath and a byte-lane data memory.
// Native stores go straight to memory; every load and every non-native store
// reads the covered word(s) first, and non-native stores are written back as
// full words after merging (read-modify-write).
//   clock, reset              : clock and asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/addr/size/signed/wdata : request fields
//   resp_valid/resp_ready     : response handshake
//   resp_rdata/resp_err       : load result and error flag
//   mem_addr/wdata/size/we/re : memory command, registered per state
//   mem_rdata                 : combinational read of the mem_addr word
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [15:0] MEM_ADDR = 16'h1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  state_e state;
  state_e next_state;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_wdata;
  logic [63:0] rd_buf;

  logic        accept;
  logic        op_we;
  logic [31:0] op_addr;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] op_wdata;

  logic [2:0]  nbytes;
  logic [3:0]  end_lane;
  logic        span;
  logic        native;
  logic [31:0] a0;
  logic [31:0] a1;
  logic        addr_err;

  logic [63:0] buf_next;
  logic [31:0] ext_rdata;
  logic [63:0] merged;

  logic        ready_d;
  logic        resp_valid_d;
  logic        resp_err_d;
  logic [31:0] resp_rdata_d;
  logic        mem_we_d;
  logic        mem_re_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_d;
  logic [1:0]  mem_size_d;

  assign accept = req_valid && (state == ST_IDLE);

  // Outputs are registered from the next state, so the decode must see the
  // request fields in the accept cycle, before they land in the latches.
  always_comb begin
    if (accept) begin
      op_we     = req_we;
      op_addr   = req_addr;
      op_size   = req_size;
      op_signed = req_signed;
      op_wdata  = req_wdata;
    end else begin
      op_we     = lat_we;
      op_addr   = lat_addr;
      op_size   = lat_size;
      op_signed = lat_signed;
      op_wdata  = lat_wdata;
    end
  end

  always_comb begin
    nbytes   = bytes_of(op_size);
    end_lane = {2'b00, op_addr[1:0]} + {1'b0, nbytes};
    span     = end_lane > 4'd4;
    native   = (op_size == SZ_BYTE) ||
               (op_size == SZ_HALF && !op_addr[0]) ||
               (op_size == SZ_WORD && op_addr[1:0] == 2'b00);
    a0       = {op_addr[31:2], 2'b00};
    a1       = a0 + 32'd4;
    // A1 wrapping past 0xFFFFFFFC lands outside the region and errors here.
    addr_err = (op_size == SZ_UNALIGNED) ||
               (a0[31:16] != MEM_ADDR) ||
               (span && a1[31:16] != MEM_ADDR);
  end

  // Buffer as it will be after this edge; lets WR0/RESP outputs register the
  // word captured in the same cycle.
  always_comb begin
    buf_next = rd_buf;
    if (state == ST_RD0) begin
      buf_next = {32'b0, mem_rdata};
    end else if (state == ST_RD1) begin
      buf_next = {mem_rdata, rd_buf[31:0]};
    end
  end

  lane_merge u_lane_merge (
    .buf_data (buf_next),
    .off      (op_addr[1:0]),
    .size     (op_size),
    .sign_ext (op_signed),
    .wdata    (op_wdata),
    .rdata    (ext_rdata),
    .merged   (merged)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd_buf     <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      state  <= next_state;
      rd_buf <= buf_next;
      if (accept) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_wdata  <= req_wdata;
      end
    end
  end

  // ST_ERR is a dead cycle so errors answer with the native-store latency.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (addr_err) begin
            next_state = ST_ERR;
          end else if (op_we && native) begin
            next_state = ST_WNAT;
          end else begin
            next_state = ST_RD0;
          end
        end
      end
      ST_ERR:  next_state = ST_RESP;
      ST_WNAT: next_state = ST_RESP;
      ST_RD0: begin
        if (span) begin
          next_state = ST_RD1;
        end else if (op_we) begin
          next_state = ST_WR0;
        end else begin
          next_state = ST_RESP;
        end
      end
      ST_RD1:  next_state = op_we ? ST_WR0 : ST_RESP;
      ST_WR0:  next_state = span ? ST_WR1 : ST_RESP;
      ST_WR1:  next_state = ST_RESP;
      ST_RESP: next_state = resp_ready ? ST_IDLE : ST_RESP;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_size_d   = SZ_BYTE;
    case (next_state)
      ST_IDLE: ready_d = 1'b1;
      ST_WNAT: begin
        // The memory replicates lanes itself, so data stays right-justified.
        mem_we_d    = 1'b1;
        mem_addr_d  = op_addr;
        mem_size_d  = op_size;
        mem_wdata_d = op_wdata;
      end
      ST_RD0: begin
        mem_re_d   = 1'b1;
        mem_addr_d = a0;
        mem_size_d = SZ_WORD;
      end
      ST_RD1: begin
        mem_re_d   = 1'b1;
        mem_addr_d = a1;
        mem_size_d = SZ_WORD;
      end
      ST_WR0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = a0;
        mem_size_d  = SZ_WORD;
        mem_wdata_d = merged[31:0];
      end
      ST_WR1: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = a1;
        mem_size_d  = SZ_WORD;
        mem_wdata_d = merged[63:32];
      end
      ST_RESP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = addr_err;
        resp_rdata_d = (addr_err || op_we) ? 32'd0 : ext_rdata;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= SZ_BYTE;
    end else begin
      req_ready  <= ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_we     <= mem_we_d;
      mem_re     <= mem_re_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_size   <= mem_size_d;
    end
  end

endmodule
